// File: rtl/calc_op_arbiter_pkg.sv
// Shared MiniCalc2 opcode encodings and arbiter state encoding.
// Imported by the operation-port arbiter; the same constants serve the UART decoder and core.
package calc_op_arbiter_pkg;

  localparam logic [1:0] OP_PUSH_LO = 2'b00;
  localparam logic [1:0] OP_PUSH_HI = 2'b01;
  localparam logic [1:0] OP_EXEC    = 2'b10;
  localparam logic [1:0] OP_INVALID = 2'b11;

  // state | meaning
  // IDLE  | no op in flight, grant on any request
  // ISSUE | one-cycle strobe of the latched op to the core
  // WAIT  | waiting for core completion or timeout
  // REJECT| invalid opcode, report done+bad-op without touching the core
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REJECT = 2'd3
  } arb_state_t;

  function automatic logic pick_winner(input logic [1:0] valid, input logic prio);
    return valid[prio] ? prio : ~prio;
  endfunction

endpackage

// File: rtl/calc_op_arbiter_if.sv
// Requester-side and core-side signals of the operation-port arbiter.
// slave = arbiter view, master = environment (requesters + core) view.
interface calc_op_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        req_valid;
  logic [1:0]        req_op0;
  logic [DATA_W-1:0] req_data0;
  logic [1:0]        req_op1;
  logic [DATA_W-1:0] req_data1;
  logic [1:0]        req_ready;
  logic [1:0]        req_done;
  logic              req_bad_op;
  logic              core_op_valid;
  logic [1:0]        core_op;
  logic [DATA_W-1:0] core_data;
  logic              core_op_done;
  logic              busy;
  logic              owner;
  logic              timeout_err;
  logic              clear_err;

  modport slave (
    input  req_valid, req_op0, req_data0, req_op1, req_data1, core_op_done, clear_err,
    output req_ready, req_done, req_bad_op, core_op_valid, core_op, core_data,
           busy, owner, timeout_err
  );

  modport master (
    output req_valid, req_op0, req_data0, req_op1, req_data1, core_op_done, clear_err,
    input  req_ready, req_done, req_bad_op, core_op_valid, core_op, core_data,
           busy, owner, timeout_err
  );
endinterface

// File: rtl/calc_op_arbiter.sv
// Round-robin arbiter sharing the MiniCalc2 op port between local buttons (req 0) and UART (req 1).
// One op in flight at a time; completion timeout sets a sticky error.
module calc_op_arbiter
  import calc_op_arbiter_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic              i_clk,
  input logic              i_reset,
  calc_op_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_t        r_state;
  arb_state_t        w_next_state;
  logic              r_prio;
  logic              r_owner;
  logic [1:0]        r_op;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_timeout_err;

  logic              w_winner;
  logic [1:0]        w_win_op;
  logic [DATA_W-1:0] w_win_data;
  logic              w_grant;
  logic              w_timeout;
  logic [1:0]        w_req_ready;
  logic [1:0]        w_req_done;
  logic              w_bad_op;
  logic              w_core_op_valid;
  logic [1:0]        w_owner_mask;

  always_comb begin
    w_next_state    = r_state;
    w_grant         = 1'b0;
    w_timeout       = 1'b0;
    w_req_ready     = 2'b00;
    w_req_done      = 2'b00;
    w_bad_op        = 1'b0;
    w_core_op_valid = 1'b0;
    w_winner        = pick_winner(bus.req_valid, r_prio);
    w_win_op        = w_winner ? bus.req_op1 : bus.req_op0;
    w_win_data      = w_winner ? bus.req_data1 : bus.req_data0;
    w_owner_mask    = r_owner ? 2'b10 : 2'b01;

    case (r_state)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          w_grant      = 1'b1;
          w_req_ready  = w_winner ? 2'b10 : 2'b01;
          w_next_state = (w_win_op == OP_INVALID) ? ST_REJECT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_core_op_valid = 1'b1;
        w_next_state    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.core_op_done) begin
          w_req_done   = w_owner_mask;
          w_next_state = ST_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout    = 1'b1;
          w_req_done   = w_owner_mask;
          w_next_state = ST_IDLE;
        end
      end
      ST_REJECT: begin
        w_req_done   = w_owner_mask;
        w_bad_op     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase

    // An op aborted by reset must not report completion or start anything new.
    if (i_reset) begin
      w_grant         = 1'b0;
      w_timeout       = 1'b0;
      w_req_ready     = 2'b00;
      w_req_done      = 2'b00;
      w_bad_op        = 1'b0;
      w_core_op_valid = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_prio        <= 1'b0;
      r_owner       <= 1'b0;
      r_op          <= 2'b00;
      r_data        <= '0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_prio  <= ~w_winner;
        r_owner <= w_winner;
        r_op    <= w_win_op;
        r_data  <= w_win_data;
      end
      if (r_state == ST_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT && !bus.core_op_done && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end else if (bus.clear_err) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.req_done      = w_req_done;
  assign bus.req_bad_op    = w_bad_op;
  assign bus.core_op_valid = w_core_op_valid;
  assign bus.core_op       = r_op;
  assign bus.core_data     = r_data;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.owner         = r_owner;
  assign bus.timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_calc_op_arbiter.sv
// Self-checking bench for calc_op_arbiter: vector table for grant/issue/reject, scoreboard on
// core issue, and hand sequences for round-robin, timeout, error clear and reset mid-op.
module tb_calc_op_arbiter;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 4;

  logic clk;
  logic reset;

  calc_op_arbiter_if #(.DATA_W(DATA_W)) bus ();

  calc_op_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] op0;
    logic [7:0] d0;
    logic [1:0] op1;
    logic [7:0] d1;
    logic       w;
    int         wait_c;
  } vec_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
  } sb_t;

  vec_t vecs[9];
  sb_t  sb[$];
  sb_t  last_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop_cmp(input string name);
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: core issue with empty scoreboard at %0t", name, $time);
    end else begin
      last_exp = sb.pop_front();
      chk({name, "_op"}, 32'(bus.core_op), 32'(last_exp.op));
      chk({name, "_data"}, 32'(bus.core_data), 32'(last_exp.data));
    end
  endtask

  // Called in an IDLE cycle, returns in the next IDLE cycle.
  task automatic run_vec(input vec_t v);
    logic [1:0] m;
    logic [1:0] xop;
    logic [7:0] xd;
    sb_t        e;
    m   = v.w ? 2'b10 : 2'b01;
    xop = v.w ? v.op1 : v.op0;
    xd  = v.w ? v.d1 : v.d0;
    bus.req_valid = v.valid;
    bus.req_op0   = v.op0;
    bus.req_data0 = v.d0;
    bus.req_op1   = v.op1;
    bus.req_data1 = v.d1;
    #1;
    chk("grant_ready", 32'(bus.req_ready), 32'(m));
    chk("grant_idle_busy", 32'(bus.busy), 0);
    if (xop != 2'b11) begin
      e.op   = xop;
      e.data = xd;
      sb.push_back(e);
    end
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("owner", 32'(bus.owner), 32'(v.w));
    chk("no_ready_after_grant", 32'(bus.req_ready), 0);
    if (xop == 2'b11) begin
      chk("rej_done", 32'(bus.req_done), 32'(m));
      chk("rej_badop", 32'(bus.req_bad_op), 1);
      chk("rej_no_issue", 32'(bus.core_op_valid), 0);
      tick();
    end else begin
      chk("issue_strobe", 32'(bus.core_op_valid), 1);
      chk("issue_no_done", 32'(bus.req_done), 0);
      sb_pop_cmp("issue");
      for (int i = 0; i < v.wait_c; i++) begin
        tick();
        chk("wait_no_strobe", 32'(bus.core_op_valid), 0);
        chk("wait_busy", 32'(bus.busy), 1);
      end
      tick();
      bus.core_op_done = 1'b1;
      #1;
      chk("done_pulse", 32'(bus.req_done), 32'(m));
      chk("done_badop", 32'(bus.req_bad_op), 0);
      chk("hold_op", 32'(bus.core_op), 32'(last_exp.op));
      chk("hold_data", 32'(bus.core_data), 32'(last_exp.data));
      tick();
      bus.core_op_done = 1'b0;
    end
    #1;
    chk("back_idle_busy", 32'(bus.busy), 0);
    chk("back_idle_done", 32'(bus.req_done), 0);
  endtask

  // Single requester grant plus issue; returns in the ISSUE cycle.
  task automatic grant_issue(input logic [1:0] valid, input logic [1:0] op, input logic [7:0] d,
                             input logic w);
    sb_t e;
    bus.req_valid = valid;
    bus.req_op0   = op;
    bus.req_data0 = d;
    bus.req_op1   = op;
    bus.req_data1 = d;
    #1;
    chk("gi_ready", 32'(bus.req_ready), w ? 2 : 1);
    e.op   = op;
    e.data = d;
    sb.push_back(e);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("gi_strobe", 32'(bus.core_op_valid), 1);
    sb_pop_cmp("gi");
  endtask

  initial begin
    vecs[0] = '{2'b01, 2'b00, 8'h3C, 2'b00, 8'h00, 1'b0, 2};
    vecs[1] = '{2'b11, 2'b01, 8'h11, 2'b10, 8'h22, 1'b1, 0};
    vecs[2] = '{2'b11, 2'b10, 8'h33, 2'b00, 8'h44, 1'b0, 1};
    vecs[3] = '{2'b11, 2'b00, 8'h55, 2'b01, 8'h66, 1'b1, 2};
    vecs[4] = '{2'b10, 2'b00, 8'h00, 2'b11, 8'hE1, 1'b1, 0};
    vecs[5] = '{2'b10, 2'b00, 8'h00, 2'b01, 8'h77, 1'b1, 0};
    vecs[6] = '{2'b11, 2'b11, 8'hE2, 2'b00, 8'h88, 1'b0, 0};
    vecs[7] = '{2'b01, 2'b10, 8'h99, 2'b00, 8'h00, 1'b0, 1};
    vecs[8] = '{2'b11, 2'b00, 8'hAA, 2'b10, 8'hBB, 1'b1, 2};

    reset             = 1'b1;
    bus.req_valid     = 2'b00;
    bus.req_op0       = 2'b00;
    bus.req_data0     = '0;
    bus.req_op1       = 2'b00;
    bus.req_data1     = '0;
    bus.core_op_done  = 1'b0;
    bus.clear_err     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    chk("rst_core_op", 32'(bus.core_op), 0);
    chk("rst_core_data", 32'(bus.core_data), 0);
    chk("rst_strobe", 32'(bus.core_op_valid), 0);
    chk("rst_done", 32'(bus.req_done), 0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both requesters held: grants alternate while prio starts at 0.
    bus.req_valid = 2'b11;
    bus.req_op0   = 2'b00;
    bus.req_data0 = 8'h01;
    bus.req_op1   = 2'b01;
    bus.req_data1 = 8'h02;
    for (int k = 0; k < 4; k++) begin
      sb_t e;
      logic w;
      w = 1'(k % 2);
      #1;
      chk("rr_ready", 32'(bus.req_ready), w ? 2 : 1);
      e.op   = w ? 2'b01 : 2'b00;
      e.data = w ? 8'h02 : 8'h01;
      sb.push_back(e);
      tick();
      chk("rr_issue_no_ready", 32'(bus.req_ready), 0);
      chk("rr_issue_strobe", 32'(bus.core_op_valid), 1);
      chk("rr_owner", 32'(bus.owner), 32'(w));
      sb_pop_cmp("rr");
      tick();
      bus.core_op_done = 1'b1;
      #1;
      chk("rr_done", 32'(bus.req_done), w ? 2 : 1);
      chk("rr_wait_no_ready", 32'(bus.req_ready), 0);
      tick();
      bus.core_op_done = 1'b0;
    end
    bus.req_valid = 2'b00;

    // Done while idle is ignored.
    bus.core_op_done = 1'b1;
    #1;
    chk("idle_done_ignored", 32'(bus.req_done), 0);
    tick();
    bus.core_op_done = 1'b0;
    #1;
    chk("idle_done_busy", 32'(bus.busy), 0);

    // Done on the final count wins over timeout.
    grant_issue(2'b01, 2'b10, 8'h5A, 1'b0);
    repeat (3) begin
      tick();
      chk("to1_wait_done", 32'(bus.req_done), 0);
    end
    tick();
    bus.core_op_done = 1'b1;
    #1;
    chk("to1_done", 32'(bus.req_done), 1);
    tick();
    bus.core_op_done = 1'b0;
    #1;
    chk("to1_no_err", 32'(bus.timeout_err), 0);
    chk("to1_busy", 32'(bus.busy), 0);

    // Timeout: done pulse four cycles after issue, sticky error, cleared by ClearErr.
    grant_issue(2'b01, 2'b00, 8'hA5, 1'b0);
    repeat (3) begin
      tick();
      chk("to2_wait_done", 32'(bus.req_done), 0);
    end
    tick();
    chk("to2_done", 32'(bus.req_done), 1);
    chk("to2_busy", 32'(bus.busy), 1);
    tick();
    chk("to2_err_set", 32'(bus.timeout_err), 1);
    chk("to2_idle", 32'(bus.busy), 0);
    chk("to2_err_held", 32'(bus.timeout_err), 1);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    #1;
    chk("to2_err_clear", 32'(bus.timeout_err), 0);

    // ClearErr in the timeout cycle: set wins.
    grant_issue(2'b01, 2'b01, 8'h0F, 1'b0);
    repeat (3) tick();
    tick();
    bus.clear_err = 1'b1;
    #1;
    chk("to3_done", 32'(bus.req_done), 1);
    tick();
    bus.clear_err = 1'b0;
    #1;
    chk("to3_set_wins", 32'(bus.timeout_err), 1);
    bus.clear_err = 1'b1;
    tick();
    bus.clear_err = 1'b0;
    #1;
    chk("to3_clear", 32'(bus.timeout_err), 0);

    // Reset while waiting: no done for the aborted op, late done ignored, prio back to 0.
    grant_issue(2'b01, 2'b00, 8'hC3, 1'b0);
    tick();
    reset            = 1'b1;
    bus.core_op_done = 1'b1;
    #1;
    chk("rmid_no_done", 32'(bus.req_done), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rmid_idle", 32'(bus.busy), 0);
    chk("rmid_core_op", 32'(bus.core_op), 0);
    chk("rmid_core_data", 32'(bus.core_data), 0);
    chk("rmid_late_done", 32'(bus.req_done), 0);
    tick();
    bus.core_op_done = 1'b0;
    begin
      vec_t v;
      v = '{2'b11, 2'b01, 8'h4D, 2'b10, 8'h4E, 1'b0, 0};
      run_vec(v);
    end

    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
